pi_ctl_sequencer: RTL and testbench

Digital controller that owns the per-lane phase-interpolator control codes (ctl_pi) and the ctl_valid strobe driven into the analog core.
It arbitrates phase-update requests from two requesters: the CDR loop and a software/JTAG manual path.
It moves each lane's code toward its captured target in slew-limited steps, using shortest modular direction.
Each step is strobed with a ctl_valid pulse and followed by a settle interval, so the PI never sees a large phase jump.

---
 rtl/pi_ctl_sequencer_pkg.sv | 6 +
 rtl/pi_ctl_sequencer_stepper.sv | 22 ++
 rtl/pi_ctl_sequencer.sv | 75 +++++++
 tb/tb_pi_ctl_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pi_ctl_sequencer_pkg.sv
// pi_ctl_sequencer_pkg: shared PI sizing constants and sequencer state type
package pi_ctl_sequencer_pkg;
  localparam int NPI = 9;
  localparam int NOUT = 4;
  typedef enum logic [2:0] {IDLE, STEP, SETUP, VALID, SETTLE} pi_seq_state_t;
endpackage

// File: rtl/pi_ctl_sequencer_stepper.sv
// pi_code_stepper: one slew-limited PI code step toward target along the shortest modular path
module pi_code_stepper
  import pi_ctl_sequencer_pkg::*;
#(
  parameter int Npi = NPI
) (
  input  logic [Npi-1:0] cur,
  input  logic [Npi-1:0] target,
  input  logic [Npi-1:0] ms,
  output logic [Npi-1:0] nxt,
  output logic           at_target
);
  localparam logic [Npi-1:0] HALF = {1'b1, {(Npi-1){1'b0}}};
  logic [Npi-1:0] d, nd;
  always_comb begin
    d = target - cur;
    nd = cur - target;
    at_target = d == '0;
    // exactly half-way round resolves to the increment direction
    nxt = (d[Npi-1] && d != HALF) ? cur - (nd < ms ? nd : ms) : cur + (d < ms ? d : ms);
  end
endmodule

// File: rtl/pi_ctl_sequencer.sv
// pi_ctl_sequencer: arbitrates CDR/software PI updates and slews ctl_pi with strobed, settled steps
module pi_ctl_sequencer
  import pi_ctl_sequencer_pkg::*;
#(
  parameter int Npi        = NPI,
  parameter int Nout       = NOUT,
  parameter int VALID_CYC  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cdr_req,
  input  logic [Nout-1:0][Npi-1:0]  cdr_code,
  output logic                      cdr_gnt,
  input  logic                      sw_req,
  input  logic [Nout-1:0][Npi-1:0]  sw_code,
  output logic                      sw_gnt,
  input  logic                      sw_prio,
  input  logic [Npi-1:0]            max_step,
  output logic [Nout-1:0][Npi-1:0]  ctl_pi,
  output logic                      ctl_valid,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = 16;
  pi_seq_state_t state, nstate;
  logic [CW-1:0] cnt, cnt_n;
  logic [Nout-1:0][Npi-1:0] target, nxt;
  logic [Nout-1:0] at;
  logic [Npi-1:0] ms;
  logic all_at, req, sel_sw, last;
  assign ms = (max_step == '0) ? Npi'(1) : max_step;
  assign all_at = &at;
  assign req = cdr_req | sw_req;
  assign sel_sw = sw_req && (sw_prio || !cdr_req);
  assign busy = state != IDLE;
  assign ctl_valid = state == VALID;
  for (genvar i = 0; i < Nout; i++) begin : g_lane
    pi_code_stepper #(.Npi(Npi)) u_step (
      .cur(ctl_pi[i]), .target(target[i]), .ms(ms), .nxt(nxt[i]), .at_target(at[i])
    );
  end
  always_comb begin
    nstate = state;
    last = cnt == CW'(state == VALID ? VALID_CYC - 1 : SETTLE_CYC - 1);
    cnt_n = (state inside {VALID, SETTLE}) && !last ? cnt + CW'(1) : '0;
    case (state)
      IDLE:    nstate = req ? STEP : IDLE;
      STEP:    nstate = all_at ? IDLE : SETUP;
      SETUP:   nstate = VALID;
      VALID:   nstate = last ? SETTLE : VALID;
      SETTLE:  nstate = !last ? SETTLE : all_at ? IDLE : STEP;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ctl_pi <= '0;
      target <= '0;
      cdr_gnt <= 1'b0;
      sw_gnt <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= cnt_n;
      cdr_gnt <= state == IDLE && cdr_req && !sel_sw;
      sw_gnt <= state == IDLE && sel_sw;
      done <= busy && nstate == IDLE;
      if (state == IDLE && req) target <= sel_sw ? sw_code : cdr_code;
      if (state == STEP) ctl_pi <= nxt;
    end
  end
endmodule

// File: tb/tb_pi_ctl_sequencer.sv
// tb_pi_ctl_sequencer: randomized self-checking bench against a cycle-level behavioural model
module tb_pi_ctl_sequencer;
  import pi_ctl_sequencer_pkg::*;
  localparam int N = NPI, L = NOUT, V = 2, S = 4, P = 2 + V + S, M = 1 << N;
  logic clk = 1'b0, rst = 1'b0;
  logic cdr_req = 1'b0, sw_req = 1'b0, sw_prio = 1'b0;
  logic [L-1:0][N-1:0] cdr_code = '0, sw_code = '0, ctl_pi;
  logic [N-1:0] max_step = '0;
  logic cdr_gnt, sw_gnt, ctl_valid, busy, done;
  int n_cmp = 0, n_bad = 0;
  int cur_m[L];
  always #5 clk = ~clk;
  pi_ctl_sequencer #(.Npi(N), .Nout(L), .VALID_CYC(V), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .cdr_req(cdr_req), .cdr_code(cdr_code), .cdr_gnt(cdr_gnt),
    .sw_req(sw_req), .sw_code(sw_code), .sw_gnt(sw_gnt), .sw_prio(sw_prio),
    .max_step(max_step), .ctl_pi(ctl_pi), .ctl_valid(ctl_valid), .busy(busy), .done(done)
  );
  // one slew-limited move toward t along the shorter way round the code circle
  function automatic int step1(input int c, input int t, input int ms);
    int d;
    d = (t - c + M) % M;
    if (d == 0) return c;
    if (d <= M / 2) return (c + (d < ms ? d : ms)) % M;
    return (c - ((M - d) < ms ? (M - d) : ms) + M) % M;
  endfunction
  task automatic test_update(input string nm, input logic rc, input logic rs,
                             input logic [L-1:0][N-1:0] cc, input logic [L-1:0][N-1:0] sc, input int ms);
    int tgt[L], e[L], tmp[L];
    int n, w, dn, ems;
    bit same, ev;
    logic win_sw;
    logic [L-1:0][N-1:0] exp_pi;
    ems = ms == 0 ? 1 : ms;
    win_sw = rs && (sw_prio || !rc);
    for (int l = 0; l < L; l++) begin
      tgt[l] = int'(win_sw ? sc[l] : cc[l]);
      tmp[l] = cur_m[l];
      e[l] = cur_m[l];
    end
    n = 0;
    forever begin
      same = 1'b1;
      for (int l = 0; l < L; l++) if (tmp[l] != tgt[l]) same = 1'b0;
      if (same) break;
      for (int l = 0; l < L; l++) tmp[l] = step1(tmp[l], tgt[l], ems);
      n++;
    end
    dn = n == 0 ? 1 : P * n;
    cdr_code = cc;
    sw_code = sc;
    max_step = N'(ms);
    cdr_req = rc;
    sw_req = rs;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(cdr_gnt || sw_gnt) && w < 20);
    n_cmp++;
    if (w != 1 || sw_gnt !== win_sw || cdr_gnt !== !win_sw || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s grant: latency %0d sw_gnt %b cdr_gnt %b busy %b, required latency 1 sw_gnt %b cdr_gnt %b busy 1",
               nm, w, sw_gnt, cdr_gnt, busy, win_sw, !win_sw);
    end
    if (!(cdr_gnt || sw_gnt)) return;
    if (win_sw) sw_req = 1'b0;
    else cdr_req = 1'b0;
    for (int t = 1; t <= dn; t++) begin
      @(negedge clk);
      if (n > 0 && t % P == 1 && (t - 1) / P < n)
        for (int l = 0; l < L; l++) e[l] = step1(e[l], tgt[l], ems);
      for (int l = 0; l < L; l++) exp_pi[l] = N'(e[l]);
      ev = n > 0 && (t - 1) % P >= 1 && (t - 1) % P <= V;
      n_cmp++;
      if (ctl_pi !== exp_pi || ctl_valid !== ev || done !== (t == dn) || busy !== (t != dn)
          || sw_gnt !== 1'b0 || cdr_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL %s t=%0d: pi %h valid %b done %b busy %b gnt %b%b, required pi %h valid %b done %b busy %b gnt 00",
                 nm, t, ctl_pi, ctl_valid, done, busy, sw_gnt, cdr_gnt, exp_pi, ev, t == dn, t != dn);
      end
    end
    for (int l = 0; l < L; l++) cur_m[l] = e[l];
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cdr_req = 1'b0;
    sw_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ctl_pi !== '0 || ctl_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sw_gnt !== 1'b0 || cdr_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: pi %h valid %b busy %b done %b gnt %b%b, required all zero",
               ctl_pi, ctl_valid, busy, done, sw_gnt, cdr_gnt);
    end
    rst = 1'b0;
    for (int l = 0; l < L; l++) cur_m[l] = 0;
    @(negedge clk);
  endtask
  task automatic test_single();
    sw_prio = 1'b0;
    test_update("single", 1'b0, 1'b1, '0, {4{9'd10}}, 16);
  endtask
  task automatic test_wrap();
    test_update("wrap_setup", 1'b0, 1'b1, '0, {9'd10, 9'd10, 9'd10, 9'd510}, 16);
    test_update("wrap", 1'b0, 1'b1, '0, {9'd10, 9'd10, 9'd10, 9'd4}, 8);
  endtask
  task automatic test_half();
    test_update("half_setup", 1'b1, 1'b0, '0, '0, 16);
    test_update("half", 1'b1, 1'b0, {9'd0, 9'd0, 9'd0, 9'd256}, '0, 8);
  endtask
  task automatic test_zero_step();
    test_update("zero_step", 1'b0, 1'b1, '0, {9'd0, 9'd0, 9'd0, 9'd256}, 8);
  endtask
  task automatic test_max_step0();
    test_update("max_step0", 1'b0, 1'b1, '0, {9'd3, 9'd2, 9'd1, 9'd259}, 0);
  endtask
  task automatic test_priority(input logic p);
    logic [L-1:0][N-1:0] cc, sc;
    for (int l = 0; l < L; l++) begin
      cc[l] = N'($urandom);
      sc[l] = N'($urandom);
    end
    sw_prio = p;
    test_update(p ? "prio_sw_first" : "prio_cdr_first", 1'b1, 1'b1, cc, sc, 40);
    test_update(p ? "prio_cdr_second" : "prio_sw_second", !p, p, cc, sc, 40);
  endtask
  task automatic test_back_to_back();
    logic [L-1:0][N-1:0] cc, sc;
    logic rc, rs, ws;
    int ms;
    for (int k = 0; k < 8; k++) begin
      for (int l = 0; l < L; l++) begin
        cc[l] = N'($urandom);
        sc[l] = N'($urandom);
      end
      rc = 1'($urandom);
      rs = rc ? 1'($urandom) : 1'b1;
      ms = int'($urandom_range(0, 40));
      sw_prio = 1'($urandom);
      ws = rs && (sw_prio || !rc);
      test_update("random", rc, rs, cc, sc, ms);
      if (rc && rs) test_update("random_loser", ws, !ws, cc, sc, ms);
    end
  endtask
  task automatic test_reset_mid();
    int w;
    sw_code = '0;
    for (int l = 0; l < L; l++) sw_code[l] = N'(cur_m[l] + 100);
    max_step = 9'd4;
    sw_req = 1'b1;
    @(negedge clk);
    sw_req = 1'b0;
    w = 0;
    while (ctl_valid !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (ctl_valid !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL reset_mid wait: ctl_valid %b after %0d cycles, required 1", ctl_valid, w);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl_valid !== 1'b0 || ctl_pi !== '0 || busy !== 1'b0 || done !== 1'b0 || sw_gnt !== 1'b0 || cdr_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: valid %b pi %h busy %b done %b gnt %b%b, required all zero",
               ctl_valid, ctl_pi, busy, done, sw_gnt, cdr_gnt);
    end
    rst = 1'b0;
    for (int l = 0; l < L; l++) cur_m[l] = 0;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_half();
    test_zero_step();
    test_max_step0();
    test_priority(1'b1);
    test_priority(1'b0);
    test_back_to_back();
    test_reset_mid();
    test_update("after_reset", 1'b1, 1'b0, {9'd20, 9'd500, 9'd7, 9'd300}, '0, 64);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
